// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared widths, MA stage state encoding and MA/WB record type.
package simplerisc_pkg;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 4;
   typedef enum logic {S_IDLE, S_WAIT} ma_state_t;
   typedef struct packed {
      logic                  is_ld;
      logic                  is_call;
      logic                  is_wb;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     pc;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     ld_result;
   } ma_wb_t;
   localparam int MA_WB_W = $bits(ma_wb_t);
endpackage

// File: rtl/ma_wb_reg.sv
// ma_wb_reg: MA/WB pipeline register; write enable is suppressed on idle cycles.
module ma_wb_reg
   import simplerisc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [MA_WB_W-1:0]    d_i,
   output logic                  wb_valid_o,
   output logic                  wb_is_ld_o,
   output logic                  wb_is_call_o,
   output logic                  wb_is_wb_o,
   output logic [REG_ADDR_W-1:0] wb_rd_o,
   output logic [DATA_W-1:0]     wb_ld_result_o,
   output logic [DATA_W-1:0]     wb_pc_o,
   output logic [DATA_W-1:0]     wb_alu_result_o
);
   ma_wb_t wb_q;
   logic   valid_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         wb_q    <= '0;
      end else begin
         valid_q <= load_i;
         if (load_i) wb_q <= ma_wb_t'(d_i);
      end
   end
   assign wb_valid_o      = valid_q;
   assign wb_is_ld_o      = wb_q.is_ld;
   assign wb_is_call_o    = wb_q.is_call;
   assign wb_is_wb_o      = valid_q & wb_q.is_wb;
   assign wb_rd_o         = wb_q.rd;
   assign wb_ld_result_o  = wb_q.ld_result;
   assign wb_pc_o         = wb_q.pc;
   assign wb_alu_result_o = wb_q.alu_result;
endmodule

// File: rtl/ma_stage.sv
// ma_stage: SimpleRisc memory-access stage with bounded req/ack data-memory handshake.
module ma_stage
   import simplerisc_pkg::*;
#(
   parameter int MAX_WAIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   output logic                  ma_ready,
   input  logic [DATA_W-1:0]     ex_pc,
   input  logic [DATA_W-1:0]     ex_alu_result,
   input  logic [DATA_W-1:0]     ex_op2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_is_ld,
   input  logic                  ex_is_st,
   input  logic                  ex_is_call,
   input  logic                  ex_is_wb,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   input  logic                  dmem_ack,
   input  logic [DATA_W-1:0]     dmem_rdata,
   output logic                  wb_valid,
   output logic                  wb_is_ld,
   output logic                  wb_is_call,
   output logic                  wb_is_wb,
   output logic [DATA_W-1:0]     wb_ld_result,
   output logic [DATA_W-1:0]     wb_pc,
   output logic [DATA_W-1:0]     wb_alu_result,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  mem_err
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   ma_state_t         state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   ma_wb_t            inst_q, inst_d, ex_rec, wb_d;
   logic              req_q, req_d, we_q, we_d, err_q, err_d;
   logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
   logic              accept, in_wait, is_mem, misal, go_mem, retire_now, ack, tmo;
   always_comb begin
      ex_rec     = '{is_ld: ex_is_ld, is_call: ex_is_call, is_wb: ex_is_wb, rd: ex_rd,
                     pc: ex_pc, alu_result: ex_alu_result, ld_result: '0};
      accept     = ex_valid & (state_q == S_IDLE);
      in_wait    = state_q == S_WAIT;
      is_mem     = ex_is_ld | ex_is_st;
      misal      = ex_alu_result[1:0] != 2'b00;
      go_mem     = accept & is_mem & ~misal;
      retire_now = accept & ~go_mem;
      ack        = in_wait & dmem_ack;
      tmo        = in_wait & ~dmem_ack & (cnt_q == CW'(MAX_WAIT - 1));
      // Misaligned accesses retire immediately without touching memory.
      wb_d           = retire_now ? ex_rec : inst_q;
      wb_d.ld_result = (ack & inst_q.is_ld) ? dmem_rdata : '0;
      inst_d  = go_mem ? ex_rec : inst_q;
      state_d = go_mem ? S_WAIT : (ack | tmo) ? S_IDLE : state_q;
      cnt_d   = (go_mem | ack | tmo) ? '0 : in_wait ? cnt_q + 1'b1 : cnt_q;
      req_d   = go_mem ? 1'b1 : (ack | tmo) ? 1'b0 : req_q;
      we_d    = go_mem ? (ex_is_st & ~ex_is_ld) : we_q;
      addr_d  = go_mem ? ex_alu_result : addr_q;
      wdata_d = go_mem ? ex_op2 : wdata_q;
      err_d   = err_q | tmo | (accept & is_mem & (misal | (ex_is_ld & ex_is_st)));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         inst_q  <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
      end
   end
   assign ma_ready   = state_q == S_IDLE;
   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign mem_err    = err_q;
   ma_wb_reg u_wb (
      .clk            (clk),
      .rst            (rst),
      .load_i         (retire_now | ack | tmo),
      .d_i            (wb_d),
      .wb_valid_o     (wb_valid),
      .wb_is_ld_o     (wb_is_ld),
      .wb_is_call_o   (wb_is_call),
      .wb_is_wb_o     (wb_is_wb),
      .wb_rd_o        (wb_rd),
      .wb_ld_result_o (wb_ld_result),
      .wb_pc_o        (wb_pc),
      .wb_alu_result_o(wb_alu_result)
   );
endmodule

// File: tb/tb_ma_stage.sv
// tb_ma_stage: directed and randomized checks of ma_stage against a transaction-level model.
module tb_ma_stage;
   localparam int MW = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ma_ready;
   logic [31:0] ex_pc = '0, ex_alu_result = '0, ex_op2 = '0;
   logic [3:0]  ex_rd = '0;
   logic        ex_is_ld = 1'b0, ex_is_st = 1'b0, ex_is_call = 1'b0, ex_is_wb = 1'b0;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        wb_valid, wb_is_ld, wb_is_call, wb_is_wb;
   logic [31:0] wb_ld_result, wb_pc, wb_alu_result;
   logic [3:0]  wb_rd;
   logic        mem_err;
   int          checks = 0;
   int          errors = 0;
   logic        exp_err = 1'b0;

   ma_stage #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ma_ready(ma_ready),
      .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_op2(ex_op2), .ex_rd(ex_rd),
      .ex_is_ld(ex_is_ld), .ex_is_st(ex_is_st), .ex_is_call(ex_is_call), .ex_is_wb(ex_is_wb),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_is_ld(wb_is_ld), .wb_is_call(wb_is_call), .wb_is_wb(wb_is_wb),
      .wb_ld_result(wb_ld_result), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // EX fields go to junk once the transfer is done, so latching is exercised.
   task automatic scramble();
      ex_valid = 1'b0;
      ex_pc = $urandom; ex_alu_result = $urandom; ex_op2 = $urandom; ex_rd = 4'($urandom);
      ex_is_ld = 1'($urandom); ex_is_st = 1'($urandom);
      ex_is_call = 1'($urandom); ex_is_wb = 1'($urandom);
   endtask

   // Caller sits at a negedge where the stage must be ready; returns at the negedge of the retire cycle.
   // delay = wait cycles before ack; delay >= MW means memory never answers.
   task automatic run_op(input logic [31:0] pc, alu, op2, input logic [3:0] rd,
                         input logic ld, st, call, wb, input int delay, input logic [31:0] rval);
      logic        mem;
      int          n;
      logic [31:0] exp_ld;
      chk("ready_at_accept", ma_ready, 1);
      ex_valid = 1'b1; ex_pc = pc; ex_alu_result = alu; ex_op2 = op2; ex_rd = rd;
      ex_is_ld = ld; ex_is_st = st; ex_is_call = call; ex_is_wb = wb;
      mem = (ld | st) && (alu[1:0] == 2'b00);
      exp_ld = '0;
      @(negedge clk);
      scramble();
      if (!mem) begin
         if (ld | st) exp_err = 1'b1;
      end else begin
         if (ld & st) exp_err = 1'b1;
         n = (delay < MW) ? delay + 1 : MW;
         for (int i = 0; i < n; i++) begin
            chk("req_high", dmem_req, 1);
            chk("we", dmem_we, st & ~ld);
            chk("addr", dmem_addr, alu);
            chk("wdata", dmem_wdata, op2);
            chk("ready_low", ma_ready, 0);
            chk("no_wb_while_wait", wb_valid, 0);
            dmem_ack = (i == delay);
            dmem_rdata = (i == delay) ? rval : $urandom;
            if (i == delay && ld) exp_ld = rval;
            @(negedge clk);
         end
         dmem_ack = 1'b0;
         if (delay >= MW) exp_err = 1'b1;
      end
      chk("wb_valid", wb_valid, 1);
      chk("wb_is_ld", wb_is_ld, ld);
      chk("wb_is_call", wb_is_call, call);
      chk("wb_is_wb", wb_is_wb, wb);
      chk("wb_rd", wb_rd, rd);
      chk("wb_pc", wb_pc, pc);
      chk("wb_alu_result", wb_alu_result, alu);
      chk("wb_ld_result", wb_ld_result, exp_ld);
      chk("req_after_retire", dmem_req, 0);
      chk("ready_at_retire", ma_ready, 1);
      chk("mem_err", mem_err, exp_err);
   endtask

   // Idle cycles with spurious acks, which the stage must ignore.
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         dmem_ack = 1'($urandom);
         dmem_rdata = $urandom;
         @(negedge clk);
         chk("idle_wb_valid", wb_valid, 0);
         chk("idle_wb_is_wb", wb_is_wb, 0);
         chk("idle_req", dmem_req, 0);
         chk("idle_err", mem_err, exp_err);
      end
      dmem_ack = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_err = 1'b0;
   endtask

   initial begin
      int          kind, dly;
      logic [31:0] a;
      repeat (2) @(negedge clk);
      chk("rst_ready", ma_ready, 1);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_addr", dmem_addr, 0);
      chk("rst_wdata", dmem_wdata, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_flags", {wb_is_ld, wb_is_call, wb_is_wb}, 0);
      chk("rst_wb_data", wb_ld_result | wb_pc | wb_alu_result, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_err", mem_err, 0);
      rst = 1'b0;
      run_op(32'h100, 32'h2A, 32'h5, 4'd3, 0, 0, 0, 1, 0, 0);
      idle(2);
      run_op(32'h104, 32'h40, 32'h0, 4'd5, 1, 0, 0, 1, 3, 32'hDEADBEEF);
      idle(1);
      run_op(32'h108, 32'h80, 32'h12345678, 4'd0, 0, 1, 0, 0, 0, 32'hCAFEF00D);
      run_op(32'h10C, 32'h77, 32'h0, 4'd9, 0, 0, 1, 1, 0, 0);
      run_op(32'h110, 32'h44, 32'h0, 4'd2, 1, 0, 0, 1, MW, 32'h1);
      idle(10);
      do_reset();
      run_op(32'h114, 32'h41, 32'h0, 4'd4, 1, 0, 0, 1, 0, 0);
      do_reset();
      run_op(32'h118, 32'h48, 32'h0, 4'd6, 1, 1, 0, 1, 1, 32'hA5A5A5A5);
      do_reset();
      chk("mid_ready", ma_ready, 1);
      ex_valid = 1'b1; ex_alu_result = 32'h200; ex_is_ld = 1'b1; ex_is_st = 1'b0;
      @(negedge clk);
      scramble();
      chk("mid_req", dmem_req, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_req", dmem_req, 0);
      chk("abort_ready", ma_ready, 1);
      chk("abort_wb", wb_valid, 0);
      idle(3);
      run_op(32'h11C, 32'h99, 32'h0, 4'd7, 0, 0, 0, 1, 0, 0);
      for (int t = 0; t < 80; t++) begin
         if (t % 16 == 15) do_reset();
         kind = int'($urandom_range(0, 4));
         dly = int'($urandom_range(0, MW + 1));
         a = $urandom;
         if (kind == 1 || kind == 2 || kind == 4) a[1:0] = 2'b00;
         if (kind == 3 && a[1:0] == 2'b00) a[0] = 1'b1;
         run_op($urandom, a, $urandom, 4'($urandom), kind == 1 || kind == 4 || (kind == 3 && a[2]),
                kind == 2 || kind == 4 || (kind == 3 && !a[2]), 1'($urandom), 1'($urandom),
                dly, $urandom);
         idle(int'($urandom_range(0, 2)));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
